// File: rtl/alu_exec_pkg.sv
// Shared widths, opcode encodings and the writeback-opcode predicate for the
// execution pipe and its register file.
package alu_exec_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int OPC_W  = 7;

  localparam logic [OPC_W-1:0] OPC_ADD = 7'h00;
  localparam logic [OPC_W-1:0] OPC_SUB = 7'h01;
  localparam logic [OPC_W-1:0] OPC_AND = 7'h02;
  localparam logic [OPC_W-1:0] OPC_OR  = 7'h03;
  localparam logic [OPC_W-1:0] OPC_XOR = 7'h04;
  localparam logic [OPC_W-1:0] OPC_SLL = 7'h05;
  localparam logic [OPC_W-1:0] OPC_SRL = 7'h06;
  localparam logic [OPC_W-1:0] OPC_SLT = 7'h07;
  localparam logic [OPC_W-1:0] OPC_SRA = 7'h08;

  // The ALU opcodes occupy a contiguous range starting at zero.
  function automatic logic is_wb_op(input logic [OPC_W-1:0] op);
    return op <= OPC_SRA;
  endfunction
endpackage

// File: rtl/alu_regfile.sv
// Register file: three combinational read ports (src1, src2, debug) with
// write-through from the single write port; r0 always reads zero.
module alu_regfile
  import alu_exec_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2:0][ADDR_W-1:0] raddr,
  output logic [2:0][DATA_W-1:0] rdata,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata
);
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= DATA_W'(i);
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
      // A write landing this cycle is forwarded so readers see the new value.
      assign rdata[gi] = (raddr[gi] == '0)                ? '0    :
                         (we && raddr[gi] == waddr)        ? wdata :
                                                             regs[raddr[gi]];
    end
  endgenerate
endmodule

// File: rtl/alu_exec_pipe3.sv
// Three-stage execute pipe (ID operand read, EX ALU, WB writeback) with a
// one-cycle RAW stall against the instruction currently in EX.
module alu_exec_pipe3
  import alu_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic              valid,
  output logic              stall,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  logic              idex_v, idex_we;
  logic [ADDR_W-1:0] idex_dest;
  logic [OPC_W-1:0]  idex_op;
  logic [DATA_W-1:0] idex_a, idex_b;
  logic              exwb_v;
  logic [ADDR_W-1:0] exwb_dest;
  logic [DATA_W-1:0] exwb_data;

  logic [2:0][ADDR_W-1:0] rf_raddr;
  logic [2:0][DATA_W-1:0] rf_rdata;
  logic [DATA_W-1:0]      alu_res;
  logic [4:0]             shamt;
  logic                   issue_we, accept;

  assign rf_raddr  = {dbg_raddr, src2, src1};
  assign dbg_rdata = rf_rdata[2];

  alu_regfile u_rf (
    .clk   (clk),
    .rst   (rst),
    .raddr (rf_raddr),
    .rdata (rf_rdata),
    .we    (exwb_v),
    .waddr (exwb_dest),
    .wdata (exwb_data)
  );

  // Only the EX stage can hold a result not yet visible through the RF bypass.
  assign stall = rst & valid & idex_v & idex_we &
                 ((src1 == idex_dest) | (src2 == idex_dest));

  assign accept   = valid & ~stall;
  assign issue_we = is_wb_op(opcode) && (dest_addr != '0);
  assign shamt    = idex_b[4:0];

  always_comb begin
    alu_res = '0;
    case (idex_op)
      OPC_ADD: alu_res = idex_a + idex_b;
      OPC_SUB: alu_res = idex_a - idex_b;
      OPC_AND: alu_res = idex_a & idex_b;
      OPC_OR:  alu_res = idex_a | idex_b;
      OPC_XOR: alu_res = idex_a ^ idex_b;
      OPC_SLL: alu_res = idex_a << shamt;
      OPC_SRL: alu_res = idex_a >> shamt;
      OPC_SLT: alu_res = DATA_W'($signed(idex_a) < $signed(idex_b));
      OPC_SRA: alu_res = $unsigned($signed(idex_a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idex_v    <= 1'b0;
      idex_we   <= 1'b0;
      idex_dest <= '0;
      idex_op   <= '0;
      idex_a    <= '0;
      idex_b    <= '0;
      exwb_v    <= 1'b0;
      exwb_dest <= '0;
      exwb_data <= '0;
    end else begin
      idex_v    <= accept;
      idex_we   <= accept & issue_we;
      idex_dest <= dest_addr;
      idex_op   <= opcode;
      idex_a    <= rf_rdata[0];
      idex_b    <= rf_rdata[1];
      exwb_v    <= idex_v & idex_we;
      // Hold the last written result on bubbles so wb_addr/wb_data stay quiet.
      if (idex_v & idex_we) begin
        exwb_dest <= idex_dest;
        exwb_data <= alu_res;
      end
    end
  end

  assign wb_valid = exwb_v;
  assign wb_addr  = exwb_dest;
  assign wb_data  = exwb_data;
endmodule
